// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multicycle core (FETCH/EXEC/MEM/HALTED) with a wait-state data bus.
// Optional feature macro CPU_MC_MUL_EN turns opcode 0110 into an unsigned MUL.
module cpu_mc #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 16,
  parameter int DADDR_W = 16
) (
  input  logic               CK,
  input  logic               RST,
  output logic [IADDR_W-1:0] IA,
  input  logic [15:0]        ID,
  output logic [DADDR_W-1:0] DA,
  inout  wire  [DATA_W-1:0]  DD,
  output logic               RW,
  output logic               DREQ,
  input  logic               DRDY,
  output logic               HALT
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SL  = 4'h4;
  localparam logic [3:0] OP_SR  = 4'h5;
`ifdef CPU_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'h6;
`endif
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_LD  = 4'hB;
  localparam logic [3:0] OP_IMM = 4'hC;
  localparam logic [3:0] OP_BEZ = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              r_state;
  state_t              w_next_state;
  logic [IADDR_W-1:0]  r_pc;
  logic [IADDR_W-1:0]  w_pc_next;
  logic [IADDR_W-1:0]  w_target;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [16];
  logic [DADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_halt;

  logic [3:0]          w_op;
  logic [3:0]          w_d;
  logic [3:0]          w_s;
  logic [3:0]          w_t;
  logic [7:0]          w_imm8;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W-1:0]   w_rt_val;
  logic [DATA_W-1:0]   w_alu;
  logic                w_alu_we;
  logic                w_is_mem_op;
  logic                w_st_active;

  assign w_op     = r_ir[15:12];
  assign w_d      = r_ir[11:8];
  assign w_s      = r_ir[7:4];
  assign w_t      = r_ir[3:0];
  assign w_imm8   = r_ir[7:0];
  assign w_rd_val = r_regs[w_d];
  assign w_rs_val = r_regs[w_s];
  assign w_rt_val = r_regs[w_t];
  assign w_target = IADDR_W'(w_imm8);

  assign w_is_mem_op = (w_op == OP_LD) || (w_op == OP_ST);

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_alu    = '0;
    w_alu_we = 1'b1;
    case (w_op)
      OP_ADD: w_alu = w_rs_val + w_rt_val;
      OP_SUB: w_alu = w_rs_val - w_rt_val;
      OP_AND: w_alu = w_rs_val & w_rt_val;
      OP_OR:  w_alu = w_rs_val | w_rt_val;
      OP_SL:  w_alu = w_rs_val << w_t;
      OP_SR:  w_alu = w_rs_val >> w_t;
`ifdef CPU_MC_MUL_EN
      OP_MUL: w_alu = w_rs_val * w_rt_val;
`endif
      OP_IMM: w_alu = DATA_W'(w_imm8);
      default: w_alu_we = 1'b0;
    endcase
  end

  // LD/ST/HLT leave PC alone in EXEC: memory ops advance it when the access completes.
  always_comb begin
    w_pc_next = r_pc + IADDR_W'(1);
    case (w_op)
      OP_BEZ: if (w_rd_val == '0) w_pc_next = w_target;
      OP_JMP: w_pc_next = w_target;
      OP_LD, OP_ST, OP_HLT: w_pc_next = r_pc;
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_is_mem_op)         w_next_state = S_MEM;
        else if (w_op == OP_HLT) w_next_state = S_HALTED;
        else                     w_next_state = S_FETCH;
      end
      S_MEM:    if (DRDY) w_next_state = S_FETCH;
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) r_state <= S_FETCH;
    else      r_state <= w_next_state;
  end

  // NOTE: the register file is reset explicitly because programs may read registers they never wrote.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_halt  <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_ir <= ID;
        S_EXEC: begin
          r_pc <= w_pc_next;
          if (w_alu_we) r_regs[w_d] <= w_alu;
          if (w_op == OP_LD) r_addr <= DADDR_W'(w_rs_val);
          if (w_op == OP_ST) begin
            r_addr  <= DADDR_W'(w_rd_val);
            r_wdata <= w_rs_val;
          end
          if (w_op == OP_HLT) r_halt <= 1'b1;
        end
        S_MEM: begin
          if (DRDY) begin
            r_pc <= r_pc + IADDR_W'(1);
            if (w_op == OP_LD) r_regs[w_d] <= DD;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset releases DD and DREQ at once.
  assign w_st_active = (r_state == S_MEM) && (w_op == OP_ST);
  assign IA   = r_pc;
  assign DA   = r_addr;
  assign DREQ = (r_state == S_MEM);
  assign RW   = ~w_st_active;
  assign HALT = r_halt;
  assign DD   = w_st_active ? r_wdata : 'z;

endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboard bench for cpu_mc: a 16-bit/16-bit instance and a 32-bit/8-bit instance run directed programs;
// every completed data access is popped from a queue of hand-computed expectations and compared.
module tb_cpu_mc;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst_a, rst_b;
  logic garbage_en;
  logic [15:0] garbage;

  logic [15:0] IA_a, ID_a, DA_a;
  wire  [15:0] DD_a;
  logic RW_a, DREQ_a, DRDY_a, HALT_a;

  logic [7:0]  IA_b, DA_b;
  logic [15:0] ID_b;
  wire  [31:0] DD_b;
  logic RW_b, DREQ_b, DRDY_b, HALT_b;

  cpu_mc u_a (
    .CK(CK), .RST(rst_a), .IA(IA_a), .ID(ID_a), .DA(DA_a), .DD(DD_a),
    .RW(RW_a), .DREQ(DREQ_a), .DRDY(DRDY_a), .HALT(HALT_a)
  );

  cpu_mc #(.DATA_W(32), .IADDR_W(8), .DADDR_W(8)) u_b (
    .CK(CK), .RST(rst_b), .IA(IA_b), .ID(ID_b), .DA(DA_b), .DD(DD_b),
    .RW(RW_b), .DREQ(DREQ_b), .DRDY(DRDY_b), .HALT(HALT_b)
  );

  logic [15:0] imem_a [256];
  logic [15:0] imem_b [256];
  logic [15:0] dmem_a [256];

  assign ID_a = garbage_en ? garbage : imem_a[IA_a[7:0]];
  assign ID_b = garbage_en ? garbage : imem_b[IA_b];
  assign DD_a = (DREQ_a && RW_a) ? dmem_a[DA_a[7:0]] : 'z;

  // Wait-state model: DRDY stays low for wait_x cycles of each access.
  int wait_a = 0, wait_b = 0;
  int wcnt_a = 0, wcnt_b = 0;
  always @(posedge CK) begin
    if (!DREQ_a) wcnt_a <= wait_a;
    else if (wcnt_a != 0) wcnt_a <= wcnt_a - 1;
    if (!DREQ_b) wcnt_b <= wait_b;
    else if (wcnt_b != 0) wcnt_b <= wcnt_b - 1;
  end
  assign DRDY_a = (wcnt_a == 0);
  assign DRDY_b = (wcnt_b == 0);

  int cyc_a = 0;
  always @(posedge CK or negedge rst_a) begin
    if (!rst_a) cyc_a <= 0;
    else        cyc_a <= cyc_a + 1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    int          cycles;
    int          at_cycle;
  } acc_t;

  acc_t q_a[$];
  acc_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] MUL_EXP =
`ifdef CPU_MC_MUL_EN
    32'd15;
`else
    32'd7;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] pc, input int cycles, input int at_cycle);
    acc_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.pc = pc; e.cycles = cycles; e.at_cycle = at_cycle;
    return e;
  endfunction

  task automatic cmp_access(input string tag, input acc_t e, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] pc, input int cnt,
                            input int cyc, input logic stable);
    check({tag, "_is_write"}, {31'd0, wr}, {31'd0, e.wr});
    check({tag, "_addr"}, addr, e.addr);
    if (e.wr) check({tag, "_wdata"}, data, e.data);
    check({tag, "_pc_during_mem"}, pc, e.pc);
    check({tag, "_dreq_cycles"}, cnt, e.cycles);
    if (e.at_cycle > 0) check({tag, "_mem_cycle_no"}, cyc, e.at_cycle);
    check({tag, "_bus_stable"}, {31'd0, stable}, 32'd1);
  endtask

  // Monitor A: one comparison group per completed access.
  initial begin
    int cnt = 0;
    logic stable = 1'b1;
    logic [15:0] da0, ia0;
    logic rw0;
    acc_t e;
    forever begin
      @(negedge CK);
      if (!rst_a || !DREQ_a) cnt = 0;
      else begin
        cnt++;
        if (cnt == 1) begin
          da0 = DA_a; ia0 = IA_a; rw0 = RW_a; stable = 1'b1;
        end else if (DA_a !== da0 || IA_a !== ia0 || RW_a !== rw0) stable = 1'b0;
        if (DRDY_a) begin
          if (q_a.size() == 0) check("a_unexpected_access", {16'd0, DA_a}, 32'hFFFF_FFFF);
          else begin
            e = q_a.pop_front();
            cmp_access("a", e, ~RW_a, {16'd0, DA_a}, {16'd0, DD_a}, {16'd0, IA_a}, cnt, cyc_a + 1, stable);
          end
          cnt = 0;
        end
      end
    end
  end

  // Monitor B.
  initial begin
    int cnt = 0;
    logic stable = 1'b1;
    logic [7:0] da0, ia0;
    logic rw0;
    acc_t e;
    forever begin
      @(negedge CK);
      if (!rst_b || !DREQ_b) cnt = 0;
      else begin
        cnt++;
        if (cnt == 1) begin
          da0 = DA_b; ia0 = IA_b; rw0 = RW_b; stable = 1'b1;
        end else if (DA_b !== da0 || IA_b !== ia0 || RW_b !== rw0) stable = 1'b0;
        if (DRDY_b) begin
          if (q_b.size() == 0) check("b_unexpected_access", {24'd0, DA_b}, 32'hFFFF_FFFF);
          else begin
            e = q_b.pop_front();
            cmp_access("b", e, ~RW_b, {24'd0, DA_b}, DD_b, {24'd0, IA_b}, cnt, 0, stable);
          end
          cnt = 0;
        end
      end
    end
  end

  task automatic fill_a();
    for (int i = 0; i < 256; i++) imem_a[i] = 16'hF000;
  endtask

  task automatic run_a(input int budget);
    int n = 0;
    rst_a = 1'b0;
    #1;
    @(negedge CK);
    rst_a = 1'b1;
    check("a_first_fetch_ia", {16'd0, IA_a}, 32'd0);
    while (!HALT_a && n < budget) begin
      @(negedge CK);
      n++;
    end
    check("a_halt_in_budget", {31'd0, HALT_a}, 32'd1);
    check("a_scoreboard_drained", q_a.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    garbage_en = 1'b1;
    garbage = 16'h0;
    for (int i = 0; i < 256; i++) begin
      imem_b[i] = 16'hF000;
      dmem_a[i] = 16'h0;
    end
    fill_a();

    // Reset held 100 time units with garbage on ID.
    for (int i = 0; i < 10; i++) begin
      garbage = 16'($urandom);
      #10;
    end
    check("rst_ia",   {16'd0, IA_a}, 32'd0);
    check("rst_da",   {16'd0, DA_a}, 32'd0);
    check("rst_rw",   {31'd0, RW_a}, 32'd1);
    check("rst_dreq", {31'd0, DREQ_a}, 32'd0);
    check("rst_halt", {31'd0, HALT_a}, 32'd0);
    check("rst_dd_z", {31'd0, (DD_a === 16'hzzzz)}, 32'd1);
    check("rst_b_ia", {24'd0, IA_b}, 32'd0);
    check("rst_b_dd_z", {31'd0, (DD_b === 32'hzzzz_zzzz)}, 32'd1);
    garbage_en = 1'b0;

    // IMM/IMM/IMM/ADD then ST with DRDY tied high: one-cycle MEM on cycle 11.
    imem_a[0] = 16'hC000; imem_a[1] = 16'hC101; imem_a[2] = 16'hC303;
    imem_a[3] = 16'h0513; imem_a[4] = 16'hA050; imem_a[5] = 16'hF000;
    wait_a = 0;
    q_a.push_back(mk(1'b1, 32'h0, 32'h0004, 32'd4, 1, 11));
    run_a(100);
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      check("halt_ia_frozen", {16'd0, IA_a}, 32'd5);
      check("halt_stays_high", {31'd0, HALT_a}, 32'd1);
    end
    check("halt_dreq_low", {31'd0, DREQ_a}, 32'd0);
    check("halt_rw_high", {31'd0, RW_a}, 32'd1);

    // LD with 3 wait cycles, then ALU corner cases observed through stores.
    fill_a();
    dmem_a[0] = 16'h1234;
    imem_a[0]  = 16'hC000; imem_a[1]  = 16'hC101; imem_a[2]  = 16'hB200; imem_a[3]  = 16'hA120;
    imem_a[4]  = 16'hC3FF; imem_a[5]  = 16'h4338; imem_a[6]  = 16'hC4FF; imem_a[7]  = 16'h3334;
    imem_a[8]  = 16'hC401; imem_a[9]  = 16'h0534; imem_a[10] = 16'hA150; imem_a[11] = 16'h1604;
    imem_a[12] = 16'hA160; imem_a[13] = 16'h5834; imem_a[14] = 16'hA180; imem_a[15] = 16'h2928;
    imem_a[16] = 16'hA190; imem_a[17] = 16'hF000;
    wait_a = 3;
    q_a.push_back(mk(1'b0, 32'h0, 32'h0,    32'd2,  4, 0));
    q_a.push_back(mk(1'b1, 32'h1, 32'h1234, 32'd3,  4, 0));
    q_a.push_back(mk(1'b1, 32'h1, 32'h0000, 32'd10, 4, 0));
    q_a.push_back(mk(1'b1, 32'h1, 32'hFFFF, 32'd12, 4, 0));
    q_a.push_back(mk(1'b1, 32'h1, 32'h0FFF, 32'd14, 4, 0));
    q_a.push_back(mk(1'b1, 32'h1, 32'h0234, 32'd16, 4, 0));
    run_a(400);

    // BEZ taken / not taken, JMP, opcode 0110 and undefined opcodes.
    fill_a();
    imem_a[0]  = 16'hC100; imem_a[1]  = 16'hD105; imem_a[2]  = 16'hC7AA;
    imem_a[5]  = 16'hC101; imem_a[6]  = 16'hD10A; imem_a[7]  = 16'hC010; imem_a[8]  = 16'hA010;
    imem_a[9]  = 16'hE00C; imem_a[12] = 16'hA070; imem_a[13] = 16'hC103; imem_a[14] = 16'hC205;
    imem_a[15] = 16'hC307; imem_a[16] = 16'h6312; imem_a[17] = 16'hA030; imem_a[18] = 16'h7FFF;
    imem_a[19] = 16'h8FFF; imem_a[20] = 16'h9FFF; imem_a[21] = 16'hA030; imem_a[22] = 16'hF000;
    wait_a = 1;
    q_a.push_back(mk(1'b1, 32'h10, 32'h0001, 32'd8,  2, 0));
    q_a.push_back(mk(1'b1, 32'h10, 32'h0000, 32'd12, 2, 0));
    q_a.push_back(mk(1'b1, 32'h10, MUL_EXP,  32'd17, 2, 0));
    q_a.push_back(mk(1'b1, 32'h10, MUL_EXP,  32'd21, 2, 0));
    run_a(300);

    // Reset asserted in the middle of a ST access.
    fill_a();
    imem_a[0] = 16'hC504; imem_a[1] = 16'hC109; imem_a[2] = 16'hA510;
    wait_a = 10;
    rst_a = 1'b0;
    #1;
    @(negedge CK);
    rst_a = 1'b1;
    n = 0;
    while (!DREQ_a && n < 50) begin
      @(negedge CK);
      n++;
    end
    @(negedge CK);
    check("midmem_dreq_high", {31'd0, DREQ_a}, 32'd1);
    check("midmem_rw_low", {31'd0, RW_a}, 32'd0);
    check("midmem_dd_driven", {16'd0, DD_a}, 32'h0009);
    check("midmem_da", {16'd0, DA_a}, 32'h0004);
    #2;
    rst_a = 1'b0;
    #1;
    check("midmem_rst_dreq", {31'd0, DREQ_a}, 32'd0);
    check("midmem_rst_rw", {31'd0, RW_a}, 32'd1);
    check("midmem_rst_dd_z", {31'd0, (DD_a === 16'hzzzz)}, 32'd1);
    check("midmem_rst_da", {16'd0, DA_a}, 32'd0);

    // 32-bit data / 8-bit PC instance: SL by 15, JMP 0xFF and PC wrap to 0.
    imem_b[0]  = 16'hD206; imem_b[1]  = 16'hA030; imem_b[2]  = 16'hF000;
    imem_b[6]  = 16'hC1FF; imem_b[7]  = 16'h411F; imem_b[8]  = 16'hC000; imem_b[9] = 16'hA010;
    imem_b[10] = 16'hC201; imem_b[11] = 16'hC355; imem_b[12] = 16'hE0FF; imem_b[255] = 16'h7000;
    wait_b = 0;
    q_b.push_back(mk(1'b1, 32'h0, 32'h007F_8000, 32'd9, 1, 0));
    q_b.push_back(mk(1'b1, 32'h0, 32'h0000_0055, 32'd1, 1, 0));
    @(negedge CK);
    rst_b = 1'b1;
    n = 0;
    while (!HALT_b && n < 200) begin
      @(negedge CK);
      n++;
    end
    check("b_halt_in_budget", {31'd0, HALT_b}, 32'd1);
    check("b_halt_ia", {24'd0, IA_b}, 32'd2);
    check("b_scoreboard_drained", q_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multicycle successor to the 16-bit IMM/ADD/LD/ST core: same instruction-bus and data-bus style (IA/ID, DA/DD/RW).
- Adds a configurable data width, a wait-state memory handshake, branches, and HALT.
- Sits between the instruction memory and the data memory in the simulation/FPGA top.

Parameters:
DATA_W, 16, register/data-bus width (>=16)
IADDR_W, 16, instruction address width; PC wraps modulo 2^IADDR_W
DADDR_W, 16, data address width; DA = low DADDR_W bits of address register

Ports:
CK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-low
IA  output  IADDR_W  instruction address (= PC)
ID  input  16  instruction word, sampled at end of FETCH
DA  output  DADDR_W  data address
DD  inout  DATA_W  data bus; driven by core only when RW=0, else high-Z
RW  output  1  1=read/idle, 0=write
DREQ  output  1  data access request, high for whole MEM state
DRDY  input  1  memory ready; access completes on rising edge with DREQ=1 and DRDY=1
HALT  output  1  high once HLT executed

Behaviour:
- Reset (RST=0, asynchronous): PC=0, R0..R15=0, state=FETCH, IA=0, DA=0, RW=1, DREQ=0, HALT=0, DD high-Z. Reset mid-MEM drops DREQ and releases DD immediately.
- Encoding: op=ID[15:12], d=ID[11:8], s=ID[7:4], t=ID[3:0], imm8=ID[7:0]. 16 registers of DATA_W bits; R0 is an ordinary writable register.
- Opcodes:
  - 0000 ADD Rd=Rs+Rt
  - 0001 SUB Rd=Rs-Rt
  - 0010 AND
  - 0011 OR
  - 0100 SL Rd=Rs<<t
  - 0101 SR Rd=Rs>>t (logical, t = 0..15 as immediate)
  - 1010 ST mem[Rd]=Rs
  - 1011 LD Rd=mem[Rs]
  - 1100 IMM Rd={zero-ext imm8}
  - 1101 BEZ: if Rd==0, PC={zero-ext imm8}, else PC+1
  - 1110 JMP PC={zero-ext imm8}
  - 1111 HLT
  - All other opcodes are NOPs (PC+1).
- Arithmetic is modulo 2^DATA_W; there are no flags.
- FSM:
  - FETCH: IA=PC; at clock edge IR<=ID; go to EXEC.
  - EXEC: ALU/IMM write Rd and set PC+1, or branch/jump updates PC; then go to FETCH. LD/ST latch address and store data, then go to MEM. HLT sets HALT=1 and goes to HALTED.
  - MEM: DREQ=1, DA=address. ST: RW=0 and DD=Rs value for the whole state. LD: RW=1.
    - Stay in MEM while DRDY=0.
    - On the edge with DRDY=1: LD writes Rd<=DD, PC+1, go to FETCH; DREQ deasserts and RW returns to 1 in the next cycle.
  - HALTED: terminal until reset; IA holds, DREQ=0, RW=1.
- Latency: ALU/IMM/branch instructions take 2 cycles. LD/ST take 3 + N cycles, where N = cycles with DRDY low.
- DRDY is ignored outside MEM. DD is never driven when RW=1.
- Branch/jump targets are zero-extended into IADDR_W. PC+1 wraps from 2^IADDR_W-1 to 0.

Optional Feature:
- Macro CPU_MC_MUL_EN.
- Defined: opcode 0110 is MUL, Rd = low DATA_W bits of Rs*Rt (unsigned), 2-cycle latency like ADD.
- Undefined: 0110 is a NOP (no register write, PC+1).

Test Plan:
- Reset: hold RST=0 for 100 time units with garbage on ID → IA=0, DA=0, RW=1, DREQ=0, HALT=0, DD=Z. Release → first fetch at IA=0.
- Program IMM R0,0; IMM R1,1; IMM R3,3; ADD R5,R1,R3; ST R5,R0 (0xA050), DRDY tied 1 → exactly one cycle with DREQ=1, RW=0, DA=0, DD=0x0004, on cycle 11 after reset release.
- LD with DRDY low for 3 cycles (mem[0]=0x1234, LD R2,R0 = 0xB200) → DREQ high for 4 cycles, DA stable, PC unchanged until completion, then R2=0x1234.
- Loop IMM R1,0; BEZ R1,0x05 → IA jumps to 5. With R1=1, BEZ falls through to PC+1. JMP 0xFF with IADDR_W=8 → PC=0xFF, then NOP → PC wraps to 0.
- ADD 0xFFFF+0x0001 (DATA_W=16) → 0x0000. With DATA_W=32, IMM 0xFF + SL by 15 → 0x007F8000. HLT → HALT=1 and IA frozen for 20 cycles.
- Opcode 0110 with R1=3, R2=5 → R3=15 with CPU_MC_MUL_EN defined; R3 unchanged and PC+1 without it. Assert RST=0 mid-MEM of a ST → DREQ=0 and DD=Z in the same time step.
